stream_demux: RTL

- Parametrised, registered 1-to-NUM_CH demultiplexer with valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry holding register, so output data is registered with 1-cycle latency.
- Stalls on one channel do not block traffic to the other channels.
- Sits between a single producer (datapath result bus) and NUM_CH independent consumers; successor to the combinational 4-way 32-bit demux.

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/stream_demux_slot.sv | 60 ++++++
 rtl/stream_demux.sv | 106 ++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants, select check and channel state type for stream_demux.
package stream_demux_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {CH_EMPTY, CH_FULL} ch_state_e;

    function automatic logic sel_valid(input int unsigned sel, input int unsigned num_ch);
        return sel < num_ch;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel of stream_demux: single-entry holding register with fill/drain logic.
// With STREAM_DEMUX_STATS_EN a saturating delivery counter is added.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef STREAM_DEMUX_STATS_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
`ifdef STREAM_DEMUX_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  cnt
`endif
);

    ch_state_e state;
    logic      drain;

    assign out_valid = (state == CH_FULL);
    assign drain     = out_valid && out_ready;
    // Pass-through ready lets a full slot accept while it drains.
    assign free      = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CH_EMPTY;
            out_data <= '0;
        end else if (fill) begin
            state    <= CH_FULL;
            out_data <= in_data;
        end else if (drain) begin
            state    <= CH_EMPTY;
            out_data <= '0;
        end
    end

`ifdef STREAM_DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stats_clr) begin
            cnt <= '0;
        end else if (drain && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH valid/ready demultiplexer; invalid selects are dropped and flagged.
// Optional statistics counters are enabled by defining STREAM_DEMUX_STATS_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     err_sel
`ifdef STREAM_DEMUX_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [(NUM_CH+1)*CNT_W-1:0] stats_cnt
`endif
);

    if (NUM_CH < 2 || NUM_CH > 16 || CNT_W < 1) begin : g_bad_cfg
        $error("stream_demux: unsupported NUM_CH or CNT_W");
    end

    logic              sel_ok;
    logic              sel_free;
    logic              accept;
    logic              drop;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] fill;

    assign sel_ok = sel_valid(32'(in_sel), NUM_CH);

    always_comb begin
        sel_free = 1'b0;
        fill     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_free = free[k];
                fill[k]  = accept;
            end
        end
    end

    // Out-of-range selects are always accepted so a bad producer cannot wedge the input.
    assign in_ready = rst_n && enable && (sel_ok ? sel_free : 1'b1);
    assign accept   = in_valid && in_ready;
    assign drop     = accept && !sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else begin
            err_sel <= drop;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        stream_demux_slot #(
            .DATA_W (DATA_W)
`ifdef STREAM_DEMUX_STATS_EN
            ,
            .CNT_W  (CNT_W)
`endif
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .fill      (fill[k]),
            .in_data   (in_data),
            .out_ready (out_ready[k]),
            .free      (free[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W])
`ifdef STREAM_DEMUX_STATS_EN
            ,
            .stats_clr (stats_clr),
            .cnt       (stats_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (stats_clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign stats_cnt[NUM_CH*CNT_W +: CNT_W] = drop_cnt;
`endif

endmodule
